i2s_fm_modulator: RTL and testbench
===================================

# i2s_fm_modulator

Downstream stage of the I2S receiver in the FPGA DDS FM path. Takes the receiver's two 32-bit channel words and its `data_updated` strobe, moves the sample event into the system clock domain, and mixes the channels to mono. It then optionally applies pre-emphasis and scales by the deviation gain. Finally it adds the carrier to produce a 32-bit phase increment (tuning word) for the DDS. A watchdog returns the output to the bare carrier when I2S frames stop arriving.

## Interface
- `DEV_SHIFT`, 8: right arithmetic shift applied to the sample×gain product.
- `TIMEOUT`, 4096: `sys_ck` cycles without a sample before silence is declared. Must be ≥ 16.
- `PE_SHIFT`, 2: pre-emphasis coefficient exponent. Used only with `FM_PREEMPHASIS_EN`.

Ports:
- `sys_ck`  in  1: system clock; the only clock of the block.
- `rst_n`  in  1: reset, synchronous and active-low.
- `first_channel`  in  32: left word from the I2S receiver, `i2s_ck` domain.
- `second_channel`  in  32: right word from the I2S receiver, `i2s_ck` domain.
- `data_updated`  in  1: new-frame strobe from the receiver, `i2s_ck` domain.
- `carrier_tw`  in  32: carrier phase increment, quasi-static.
- `dev_gain`  in  16: unsigned deviation gain, quasi-static.
- `mute`  in  1: force the output to carrier only.
- `tuning_word`  out  32: DDS phase increment.
- `tw_valid`  out  1: one-cycle pulse whenever `tuning_word` is updated.
- `no_signal`  out  1: watchdog expired; held until the next sample.

## Operation
- **Sync:** `data_updated` passes through two flops `s1`→`s2`, then `s3`. The capture strobe is `cap = s2 & ~s3`.
- **Input constraints:** `data_updated` high ≥ 2 `sys_ck` periods. Channel words stable ≥ 4 `sys_ck` periods after `data_updated` rises. Channels are sampled only on `cap`.
- **S1, capture:** `l = first_channel[31:24+...]`, specifically `l = first_channel[31:8]` and `r = second_channel[31:8]`, both signed 24-bit.
- **S2, mono:** `m = (l + r) >>> 1`.
  - The sum is formed at 25 bits; the arithmetic shift returns it to 24 bits.
  - No overflow is possible.
- **S3, emphasis:** `y = m` (see Configuration).
- **S4, scale:** `p = (y * $signed({1'b0,dev_gain})) >>> DEV_SHIFT`.
  - Full product width is 41 bits signed.
  - The result is sign-extended or truncated to 32 bits.
- **S5, output:**
  - `tuning_word = mute ? carrier_tw : carrier_tw + p`, computed modulo 2^32 with no saturation.
  - `tw_valid = 1` for one cycle.
- **Watchdog:**
  - A counter increments every cycle and saturates at `TIMEOUT`.
  - It clears to 0 on `cap`.
  - When it reaches `TIMEOUT`: `no_signal` is set to 1, `tuning_word` is loaded with `carrier_tw`, and `tw_valid` pulses once. There is no repeat pulse while the counter stays saturated.
  - `no_signal` clears on `cap`.
  - If `cap` and timeout occur in the same cycle, `cap` wins: the counter is cleared and there is no timeout pulse.
- **Reset values:**
  - `tuning_word = 0`, `tw_valid = 0`, `no_signal = 1`.
  - All pipeline valids, sync flops, counter and history are 0.
- **Reset mid-pipeline:** in-flight samples are discarded and no `tw_valid` is produced.

## Timing
- Let E0 be the first `sys_ck` edge at which `s1` samples `data_updated = 1`.
- `cap` is high between E1 and E2. S1 registers at E2.
- Stages register at E3, E4, E5 and E6. `tw_valid` is high for the cycle following E6.
- Fixed latency: 7 edges, E0 to E6 inclusive. Latency is identical with and without the macro, because S3 is always a register stage.
- Fully pipelined, with a throughput of one sample per `cap`. There is no backpressure and overrun cannot occur.
- `mute` and `carrier_tw` are sampled at E6. `dev_gain` is sampled at E5.
- Between pulses, `tuning_word` holds its value.

## Configuration
- **`FM_PREEMPHASIS_EN` defined:**
  - S3 computes `y = sat24(m + ((m - m_prev) >>> PE_SHIFT))`. The intermediate is 26-bit signed, clamped to [-0x800000, 0x7FFFFF].
  - `m_prev` (reset 0) updates on each S3 valid.
  - `m_prev` clears to 0 when the watchdog expires.
- **Undefined:** S3 is a plain register with `y = m`, and `m_prev` logic is absent.

## Test plan
Unless stated, the bench uses `DEV_SHIFT=8` and `dev_gain=0x0100`, and the macro is undefined.

- **Positive sample:** `carrier_tw=0x40000000`; frame L=R=0x10000000 → one `tw_valid`, `tuning_word=0x40100000`, 7 edges after E0; `no_signal` drops.
- **Negative and cancelling samples:**
  - L=R=0x80000000 → `0x3F800000`.
  - L=0x10000000, R=0xF0000000 → `0x40000000`.
- **Wrap and mute:**
  - `carrier_tw=0xFFFFFF00`, L=R=0x00010000 → `0x00000000`.
  - Same frame with `mute=1` → `0xFFFFFF00`.
- **Watchdog:**
  - After the last frame, no `data_updated` for `TIMEOUT` cycles → `no_signal=1`, a single `tw_valid` with `tuning_word=carrier_tw`, and no further pulses.
  - The next frame clears `no_signal`.
- **Pre-emphasis** (`FM_PREEMPHASIS_EN`, `PE_SHIFT=1`): frames with mono 0, then 0x100000, then 0x100000 → `p` = 0, 0x180000, 0x100000.
- **Saturation and reset** (`FM_PREEMPHASIS_EN`, `PE_SHIFT=1`):
  - Mono step 0 → 0x7FFFFF gives `p=0x7FFFFF`.
  - Asserting `rst_n=0` at E4 gives no `tw_valid` and `tuning_word=0`.

Source files
------------

// File: rtl/i2s_fm_modulator.sv
// -----------------------------------------------------------------------------
// i2s_fm_modulator
//
// Turns I2S audio frames into a DDS phase increment for FM. The receiver's
// data_updated strobe is brought into sys_ck and edge-detected. On that edge
// both channel words are captured and mixed to mono. The mono sample is
// optionally pre-emphasised, scaled by the deviation gain and added to the
// carrier tuning word. A watchdog falls back to the bare carrier when frames
// stop arriving.
//
// Optional feature macro: FM_PREEMPHASIS_EN
//    Defined: stage 3 applies y = sat24(m + ((m - m_prev) >>> PE_SHIFT)).
//    Undefined: stage 3 is a plain register.
//    Latency is 7 edges from the first sync sample in both builds.
//
// Parameters:
//    DEV_SHIFT  right arithmetic shift applied to sample*gain
//    TIMEOUT    sys_ck cycles without a sample before no_signal (>= 16)
//    PE_SHIFT   pre-emphasis coefficient exponent (macro build only)
//
// Ports:
//    sys_ck          system clock, the only clock
//    rst_n           synchronous active-low reset
//    first_channel   left word  (i2s_ck domain, sampled on capture strobe)
//    second_channel  right word (i2s_ck domain, sampled on capture strobe)
//    data_updated    new-frame strobe (i2s_ck domain)
//    carrier_tw      carrier phase increment
//    dev_gain        unsigned deviation gain
//    mute            force output to carrier only
//    tuning_word     DDS phase increment
//    tw_valid        one-cycle pulse when tuning_word is reloaded
//    no_signal       watchdog expired; held until the next sample
// -----------------------------------------------------------------------------
module i2s_fm_modulator #(
   parameter int DEV_SHIFT = 8,
   parameter int TIMEOUT   = 4096,
   parameter int PE_SHIFT  = 2
) (
   input  logic        sys_ck,
   input  logic        rst_n,
   input  logic [31:0] first_channel,
   input  logic [31:0] second_channel,
   input  logic        data_updated,
   input  logic [31:0] carrier_tw,
   input  logic [15:0] dev_gain,
   input  logic        mute,
   output logic [31:0] tuning_word,
   output logic        tw_valid,
   output logic        no_signal
);

   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_PRE = CW'(TIMEOUT - 1);

   logic                s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic                cap;
   logic                timeout;
   logic                v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
   logic signed [23:0]  l_q, l_d, r_q, r_d, m_q, m_d, y_q, y_d;
   logic signed [31:0]  p_q, p_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [31:0]         tuning_word_q, tuning_word_d;
   logic                tw_valid_q, tw_valid_d;
   logic                no_signal_q, no_signal_d;
   logic signed [24:0]  sum25;
   logic signed [40:0]  prod41, scaled41;
`ifdef FM_PREEMPHASIS_EN
   logic signed [23:0]  m_prev_q, m_prev_d;
   logic signed [25:0]  diff26, shift26, emph26;
   logic signed [23:0]  sat24;
`endif

   // Low audio bits, the LSB lost by the mono halving and the product bits
   // above the 32-bit result are intentionally discarded.
   logic unused_bits;
   assign unused_bits = ^{first_channel[7:0], second_channel[7:0], sum25[0], scaled41[40:32]};

   always_comb begin
      // Two-flop synchroniser plus one flop for rising-edge detection.
      s1_d = data_updated;
      s2_d = s1_q;
      s3_d = s2_q;
      cap  = s2_q & ~s3_q;

      // Expiry is the transition into saturation; a capture in the same
      // cycle clears the counter instead, so it suppresses the expiry.
      timeout = ~cap && (cnt_q == CNT_PRE);
      if (cap)
         cnt_d = '0;
      else if (cnt_q == CNT_MAX)
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + CW'(1);

      // S1: capture the top 24 bits of each channel.
      v1_d = cap;
      l_d  = cap ? first_channel[31:8]  : l_q;
      r_d  = cap ? second_channel[31:8] : r_q;

      // S2: mono mix at 25 bits, halved back to 24 (cannot overflow).
      v2_d  = v1_q;
      sum25 = {l_q[23], l_q} + {r_q[23], r_q};
      m_d   = v1_q ? sum25[24:1] : m_q;

      // S3: emphasis stage (always a register so latency is build-invariant).
      v3_d = v2_q;
`ifdef FM_PREEMPHASIS_EN
      diff26  = {{2{m_q[23]}}, m_q} - {{2{m_prev_q[23]}}, m_prev_q};
      shift26 = diff26 >>> PE_SHIFT;
      emph26  = {{2{m_q[23]}}, m_q} + shift26;
      // Fits in 24 bits only when the top three bits agree.
      if (emph26[25:23] == 3'b000 || emph26[25:23] == 3'b111)
         sat24 = emph26[23:0];
      else if (emph26[25])
         sat24 = 24'sh800000;
      else
         sat24 = 24'sh7FFFFF;
      y_d = v2_q ? sat24 : y_q;
      // History restarts from silence after the watchdog fires.
      if (v2_q)
         m_prev_d = m_q;
      else if (timeout)
         m_prev_d = '0;
      else
         m_prev_d = m_prev_q;
`else
      y_d = v2_q ? m_q : y_q;
`endif

      // S4: deviation scaling; the gain is unsigned, so it gets a zero MSB.
      v4_d     = v3_q;
      prod41   = y_q * $signed({1'b0, dev_gain});
      scaled41 = prod41 >>> DEV_SHIFT;
      p_d      = v3_q ? scaled41[31:0] : p_q;

      // S5: output, modulo 2^32, or carrier-only on watchdog expiry.
      tw_valid_d    = 1'b0;
      tuning_word_d = tuning_word_q;
      if (v4_q) begin
         tw_valid_d    = 1'b1;
         tuning_word_d = mute ? carrier_tw : carrier_tw + p_q;
      end else if (timeout) begin
         tw_valid_d    = 1'b1;
         tuning_word_d = carrier_tw;
      end

      if (cap)
         no_signal_d = 1'b0;
      else if (timeout)
         no_signal_d = 1'b1;
      else
         no_signal_d = no_signal_q;
   end

   always_ff @(posedge sys_ck) begin
      if (!rst_n) begin
         s1_q          <= 1'b0;
         s2_q          <= 1'b0;
         s3_q          <= 1'b0;
         v1_q          <= 1'b0;
         v2_q          <= 1'b0;
         v3_q          <= 1'b0;
         v4_q          <= 1'b0;
         l_q           <= '0;
         r_q           <= '0;
         m_q           <= '0;
         y_q           <= '0;
         p_q           <= '0;
         cnt_q         <= '0;
         tuning_word_q <= '0;
         tw_valid_q    <= 1'b0;
         no_signal_q   <= 1'b1;
`ifdef FM_PREEMPHASIS_EN
         m_prev_q      <= '0;
`endif
      end else begin
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         s3_q          <= s3_d;
         v1_q          <= v1_d;
         v2_q          <= v2_d;
         v3_q          <= v3_d;
         v4_q          <= v4_d;
         l_q           <= l_d;
         r_q           <= r_d;
         m_q           <= m_d;
         y_q           <= y_d;
         p_q           <= p_d;
         cnt_q         <= cnt_d;
         tuning_word_q <= tuning_word_d;
         tw_valid_q    <= tw_valid_d;
         no_signal_q   <= no_signal_d;
`ifdef FM_PREEMPHASIS_EN
         m_prev_q      <= m_prev_d;
`endif
      end
   end

   assign tuning_word = tuning_word_q;
   assign tw_valid    = tw_valid_q;
   assign no_signal   = no_signal_q;

endmodule

// File: tb/tb_i2s_fm_modulator.sv
// -----------------------------------------------------------------------------
// tb_i2s_fm_modulator
//
// Bench for i2s_fm_modulator.
//
// Stimulus: a frame is a data_updated pulse with stable channel words. The
// bench records the edge index E0 of each frame.
//
// Reference model: computes from E0 when the watchdog clears (E0+2), when
// the history stage sees the sample (E0+4) and when the output pulse occurs
// (E0+6). Each value uses plain integer arithmetic.
//
// Checking: the model is compared with the DUT on every falling edge. A few
// literal values are also checked directly.
// -----------------------------------------------------------------------------
module tb_i2s_fm_modulator;

   localparam int DEV_SHIFT = 8;
   localparam int TIMEOUT   = 64;
   localparam int PE_SHIFT  = 1;
   localparam int MAXF      = 512;

   logic        sys_ck         = 1'b0;
   logic        rst_n          = 1'b0;
   logic [31:0] first_channel  = '0;
   logic [31:0] second_channel = '0;
   logic        data_updated   = 1'b0;
   logic [31:0] carrier_tw     = 32'h40000000;
   logic [15:0] dev_gain       = 16'h0100;
   logic        mute           = 1'b0;
   logic [31:0] tuning_word;
   logic        tw_valid;
   logic        no_signal;

   i2s_fm_modulator #(
      .DEV_SHIFT(DEV_SHIFT),
      .TIMEOUT  (TIMEOUT),
      .PE_SHIFT (PE_SHIFT)
   ) dut (
      .sys_ck        (sys_ck),
      .rst_n         (rst_n),
      .first_channel (first_channel),
      .second_channel(second_channel),
      .data_updated  (data_updated),
      .carrier_tw    (carrier_tw),
      .dev_gain      (dev_gain),
      .mute          (mute),
      .tuning_word   (tuning_word),
      .tw_valid      (tw_valid),
      .no_signal     (no_signal)
   );

   always #5 sys_ck = ~sys_ck;

   // Edge counter plus the input values as seen by each rising edge.
   int          cyc    = 0;
   logic        rst_s  = 1'b0;
   logic        mute_s = 1'b0;
   logic [31:0] car_s  = '0;
   logic [15:0] gain_s = '0;
   logic [15:0] gain_p = '0;
   always @(posedge sys_ck) begin
      cyc    <= cyc + 1;
      rst_s  <= rst_n;
      mute_s <= mute;
      car_s  <= carrier_tw;
      gain_s <= dev_gain;
      gain_p <= gain_s;
   end

   // Frame log written by the stimulus, consumed by the model.
   int                 fr_e0 [MAXF];
   logic signed [23:0] fr_l  [MAXF];
   logic signed [23:0] fr_r  [MAXF];
   int                 fr_y  [MAXF];
   int                 nfr    = 0;
   int                 rd_clr = 0;
   int                 rd_s3  = 0;
   int                 rd_out = 0;

   int tests = 0;
   int fails = 0;

   // Literal-expectation requests from the stimulus, served by the checker.
   int          pin_seq  = 0;
   int          pin_done = 0;
   logic [31:0] pin_tw   = '0;
   logic        pin_ns   = 1'b0;
   string       pin_name = "";

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
      end
   endtask

   // ---------------- behavioural model + checker ----------------
   int          last_clr = 0;
   int          mprev    = 0;
   logic        ns_exp   = 1'b1;
   logic [31:0] tw_exp   = '0;

   always @(negedge sys_ck) begin : compare
      logic        exp_v;
      int          l, r, m, t;
      longint      pr;
      logic [31:0] p32;
      if (cyc >= 1) begin
         exp_v = 1'b0;
         if (!rst_s) begin
            rd_clr   = nfr;
            rd_s3    = nfr;
            rd_out   = nfr;
            last_clr = cyc;
            ns_exp   = 1'b1;
            tw_exp   = '0;
            mprev    = 0;
         end else begin
            if (rd_clr < nfr && fr_e0[rd_clr] + 2 == cyc) begin
               last_clr = cyc;
               ns_exp   = 1'b0;
               rd_clr++;
            end else if (cyc - last_clr == TIMEOUT) begin
               exp_v  = 1'b1;
               tw_exp = car_s;
               ns_exp = 1'b1;
               mprev  = 0;
               $display("[TB] cyc=%0d watchdog expiry: expect tw=%h, dut tw=%h", cyc, tw_exp, tuning_word);
            end
            if (rd_s3 < nfr && fr_e0[rd_s3] + 4 == cyc) begin
               l = fr_l[rd_s3];
               r = fr_r[rd_s3];
               m = (l + r) >>> 1;
`ifdef FM_PREEMPHASIS_EN
               t = m + ((m - mprev) >>> PE_SHIFT);
               if (t > 8388607)  t = 8388607;
               if (t < -8388608) t = -8388608;
               mprev = m;
`else
               t = m;
`endif
               fr_y[rd_s3] = t;
               rd_s3++;
            end
            if (rd_out < nfr && fr_e0[rd_out] + 6 == cyc) begin
               pr     = (longint'(fr_y[rd_out]) * longint'(gain_p)) >>> DEV_SHIFT;
               p32    = pr[31:0];
               tw_exp = mute_s ? car_s : car_s + p32;
               exp_v  = 1'b1;
               $display("[TB] cyc=%0d sample l=%h r=%h gain=%h mute=%0b: expect tw=%h, dut tw=%h",
                        cyc, fr_l[rd_out], fr_r[rd_out], gain_p, mute_s, tw_exp, tuning_word);
               rd_out++;
            end
         end
         chk("tw_valid", {31'd0, tw_valid}, {31'd0, exp_v});
         chk("tuning_word", tuning_word, tw_exp);
         chk("no_signal", {31'd0, no_signal}, {31'd0, ns_exp});
         if (pin_seq != pin_done) begin
            chk({pin_name, "_tw"}, tuning_word, pin_tw);
            chk({pin_name, "_ns"}, {31'd0, no_signal}, {31'd0, pin_ns});
            pin_done = pin_seq;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge sys_ck);
      #1;
   endtask

   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      first_channel  = a;
      second_channel = b;
      data_updated   = 1'b1;
      fr_e0[nfr]     = cyc + 1;
      fr_l[nfr]      = a[31:8];
      fr_r[nfr]      = b[31:8];
      nfr            = nfr + 1;
      step();
      step();
      data_updated   = 1'b0;
   endtask

   task automatic frame(input logic [31:0] a, input logic [31:0] b, input int gap);
      launch(a, b);
      repeat (gap) step();
   endtask

   task automatic pin(input logic [31:0] tw, input logic ns, input string name);
      pin_tw   = tw;
      pin_ns   = ns;
      pin_name = name;
      pin_seq  = pin_seq + 1;
      step();
      step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] pick_word();
      logic [31:0] w;
      case ($urandom_range(0, 3))
         0:       w = 32'h7FFFFF00;
         1:       w = 32'h80000000;
         default: w = $urandom;
      endcase
      return w;
   endfunction

   initial begin : stim
      int tgt;
      int gap;
      repeat (3) step();
      rst_n = 1'b1;
      pin(32'h0, 1'b1, "after_reset");

`ifndef FM_PREEMPHASIS_EN
      frame(32'h10000000, 32'h10000000, 8);
      pin(32'h40100000, 1'b0, "positive");
      frame(32'h80000000, 32'h80000000, 8);
      pin(32'h3F800000, 1'b0, "negative");
      frame(32'h10000000, 32'hF0000000, 8);
      pin(32'h40000000, 1'b0, "cancel");
      carrier_tw = 32'hFFFFFF00;
      frame(32'h00010000, 32'h00010000, 8);
      pin(32'h00000000, 1'b0, "wrap");
      mute = 1'b1;
      frame(32'h00010000, 32'h00010000, 8);
      pin(32'hFFFFFF00, 1'b0, "mute");
      mute = 1'b0;
`endif

      // Watchdog: expiry, single pulse, recovery on the next frame.
      carrier_tw = 32'h12345678;
      repeat (TIMEOUT + 10) step();
      pin(32'h12345678, 1'b1, "watchdog");
      frame(32'h10000000, 32'h10000000, 8);
`ifdef FM_PREEMPHASIS_EN
      pin(32'h124C5678, 1'b0, "recover");
`else
      pin(32'h12445678, 1'b0, "recover");
`endif

      // A capture that lands on the expiry cycle wins.
      launch(32'h01000000, 32'h02000000);
      tgt = fr_e0[nfr-1] + 2 + TIMEOUT - 3;
      while (cyc < tgt) step();
      frame(32'h03000000, 32'h04000000, 8);

      // Randomized frames, with back-to-back and long (watchdog) gaps.
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 4) == 0) mute = ~mute;
         if ($urandom_range(0, 3) == 0) carrier_tw = $urandom;
         if ($urandom_range(0, 3) == 0) dev_gain = 16'($urandom);
         gap = ($urandom_range(0, 9) == 0) ? TIMEOUT + int'($urandom_range(0, 20))
                                           : int'($urandom_range(2, 6));
         frame(pick_word(), pick_word(), gap);
      end
      mute       = 1'b0;
      dev_gain   = 16'h0100;
      carrier_tw = 32'h40000000;
      repeat (10) step();

      // Reset while a sample is at stage E4: it must vanish.
      launch(32'h10000000, 32'h10000000);
      step();
      step();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      pin(32'h0, 1'b1, "reset_mid");
      repeat (12) step();

`ifdef FM_PREEMPHASIS_EN
      do_reset();
      frame(32'h00000000, 32'h00000000, 8);
      pin(32'h40000000, 1'b0, "pe_0");
      frame(32'h10000000, 32'h10000000, 8);
      pin(32'h40180000, 1'b0, "pe_step");
      frame(32'h10000000, 32'h10000000, 8);
      pin(32'h40100000, 1'b0, "pe_hold");
      do_reset();
      frame(32'h00000000, 32'h00000000, 8);
      frame(32'h7FFFFF00, 32'h7FFFFF00, 8);
      pin(32'h407FFFFF, 1'b0, "pe_sat");
`endif

      repeat (TIMEOUT + 10) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : guard
      #1000000;
      $display("FAIL global_timeout cyc=%0d got=running expected=finished", cyc);
      $fatal(1);
   end

endmodule
